uart_rx_frame: RTL and testbench

- Asynchronous serial receiver: 8N1 (optionally 8E1/8O1) frames on a single line.
- Produces the one-cycle `rx_done` strobe and `rx_data` byte consumed directly by the command-decode stage downstream (g/p/r command letters).
- Sits between the board RX pin and the control block, in the same `clk` domain.
- Reports framing and parity errors.

---
 rtl/uart_rx_frame.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 serial receiver with a two-flop input synchronizer and one-cycle done/error strobes.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1, sense chosen by PARITY_ODD).
module uart_rx_frame #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int unsigned    CPB       = CLK_FREQ / BAUD;
    localparam int unsigned    HALF      = CPB / 2;
    localparam int unsigned    CW        = $clog2(CPB);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(HALF - 1);
    localparam logic           PAR_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_rxs;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_par_bad;
    logic [7:0]    r_rx_data;
    logic          r_rx_done;
    logic          r_frame_err;
    logic          w_cnt_last;
    logic          w_half_last;
    logic          w_stop_sample;
    logic          w_enter;

    assign w_cnt_last    = (r_cnt == CNT_LAST);
    assign w_half_last   = (r_cnt == HALF_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_cnt_last;
    assign w_enter       = (w_state_nxt != r_state);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_half_last) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_cnt_last && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (w_cnt_last) w_state_nxt = S_STOP;
            end
            // Leaving mid-stop-bit lets a following start edge be seen on the very next cycle.
            S_STOP: begin
                if (w_cnt_last) w_state_nxt = r_rxs ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (r_rxs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (r_state != S_IDLE);
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1     <= 1'b1;
            r_rxs       <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par_bad   <= 1'b0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1     <= rxd;
            r_rxs       <= r_sync1;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (w_enter) begin
                r_cnt     <= '0;
                r_bit_idx <= '0;
            end else if (r_state != S_IDLE && r_state != S_BREAK) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                if (r_state == S_DATA && w_cnt_last) r_bit_idx <= r_bit_idx + 1'b1;
            end

            if (r_state == S_DATA && w_cnt_last) r_shift[r_bit_idx] <= r_rxs;

            if (r_state == S_START) begin
                r_par_bad <= 1'b0;
            end else if (r_state == S_PARITY && w_cnt_last) begin
                r_par_bad <= r_rxs ^ (^r_shift) ^ PAR_SENSE;
            end

            // A low stop bit outranks a parity mismatch.
            if (w_stop_sample) begin
                if (!r_rxs) begin
                    r_frame_err <= 1'b1;
                end else if (r_par_bad) begin
`ifdef UART_RX_PARITY_EN
                    r_parity_err <= 1'b1;
`endif
                end else begin
                    r_rx_done <= 1'b1;
                    r_rx_data <= r_shift;
                end
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: vector table, hand-written corner sequences and random frames
// checked against an event scoreboard built from the frame-timing and parity rules.
module tb_uart_rx_frame;

    localparam int unsigned CLK_FREQ   = 1000000;
    localparam int unsigned BAUD       = 100000;
    localparam int unsigned CPB        = CLK_FREQ / BAUD;
    localparam int unsigned HALF       = CPB / 2;
    localparam int unsigned SYNC_LAT   = 3;
    localparam int unsigned PAR_ODD_TB = 0;
`ifdef UART_RX_PARITY_EN
    localparam logic WITH_PAR = 1'b1;
`else
    localparam logic WITH_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    uart_rx_frame #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .PARITY_ODD (PAR_ODD_TB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // flags = {rx_done, frame_err, parity_err}
    typedef struct {
        logic [2:0]  flags;
        logic [7:0]  data;
        int unsigned at;
    } ev_t;
    ev_t exp_q[$];

    logic [7:0] model_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t ev;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_pulse: got none expected flags %b at cycle %0d", exp_q[0].flags, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        if (rx_done || frame_err || parity_err) begin
            check("pulse_onehot", 32'($countones({rx_done, frame_err, parity_err})), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got flags %b expected none (cycle %0d)",
                         {rx_done, frame_err, parity_err}, cyc);
            end else begin
                ev = exp_q.pop_front();
                check("pulse_cycle", cyc, ev.at);
                check("pulse_kind", 32'({rx_done, frame_err, parity_err}), 32'(ev.flags));
                if (ev.flags == 3'b100) check("pulse_data", 32'(rx_data), 32'(ev.data));
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line_bit(input logic b);
        rxd = b;
        tick(CPB);
    endtask

    // Called just after a rising edge; predicts the outcome from the frame rules, then drives the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        ev_t         ev;
        logic        par_bit;
        int unsigned t0;
        t0      = cyc;
        par_bit = (^d) ^ PAR_ODD_TB[0] ^ bad_par;
        ev.data = d;
        ev.at   = t0 + SYNC_LAT + HALF + 9 * CPB + (WITH_PAR ? CPB : 0);
        if (!stop) begin
            ev.flags = 3'b010;
        end else if (WITH_PAR && ((^{d, par_bit}) != PAR_ODD_TB[0])) begin
            ev.flags = 3'b001;
        end else begin
            ev.flags   = 3'b100;
            model_data = d;
        end
        exp_q.push_back(ev);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        if (WITH_PAR) line_bit(par_bit);
        line_bit(stop);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned gap_bits;
        logic [7:0]  exp_rx_data;
        logic        exp_busy;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h70, 1'b1, 2, 8'h70, 1'b0};
        vecs[1] = '{8'h67, 1'b1, 0, 8'h67, 1'b0};
        vecs[2] = '{8'h72, 1'b1, 3, 8'h72, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 2, 8'h72, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};

        tick(3);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_done", 32'(rx_done), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_rx_busy", 32'(rx_busy), 32'd0);
        resetn = 1'b1;
        tick(3 * CPB);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            check("vec_rx_data", 32'(rx_data), 32'(vecs[i].exp_rx_data));
            check("vec_rx_busy", 32'(rx_busy), 32'(vecs[i].exp_busy));
            rxd = 1'b1;
            tick(vecs[i].gap_bits * CPB);
        end

        // Start-bit glitch shorter than half a bit is rejected.
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(2);
        check("glitch_busy_during", 32'(rx_busy), 32'd1);
        tick(2 * CPB);
        check("glitch_busy_after", 32'(rx_busy), 32'd0);
        check("glitch_rx_data", 32'(rx_data), 32'(model_data));

        // Low stop bit followed by a held-low line.
        send_frame(8'h55, 1'b0, 1'b0);
        tick(50);
        check("break_busy_held", 32'(rx_busy), 32'd1);
        check("break_rx_data", 32'(rx_data), 32'(model_data));
        rxd = 1'b1;
        tick(2);
        check("break_busy_edge", 32'(rx_busy), 32'd1);
        tick(2);
        check("break_busy_release", 32'(rx_busy), 32'd0);
        tick(CPB);

        // Reset after data bit 3 of an 0xA5 frame.
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'(8'hA5 >> i));
        resetn = 1'b0;
        rxd    = 1'b1;
        tick(2);
        check("abort_rx_busy", 32'(rx_busy), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        model_data = 8'h00;
        resetn = 1'b1;
        tick(2 * CPB);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("after_abort_rx_data", 32'(rx_data), 32'hA5);
        tick(CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        check("par_bad_rx_data", 32'(rx_data), 32'hA5);
        tick(CPB);
        send_frame(8'h03, 1'b1, 1'b0);
        check("par_good_rx_data", 32'(rx_data), 32'h03);
        tick(CPB);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [7:0]  d;
            logic        stop;
            int unsigned gap;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(d, stop, WITH_PAR && ($urandom_range(0, 5) == 0));
            check("rand_rx_data", 32'(rx_data), 32'(model_data));
            rxd = 1'b1;
            tick(gap * CPB);
        end

        tick(3 * CPB);
        check("rand_rx_data_hold", 32'(rx_data), 32'(model_data));
        check("pending_events", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
